// File: rtl/seq_comp_pkg.sv
// Shared types and default sizing for the sequential magnitude comparator.
package seq_comp_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_comp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module seq_comp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  // Exactly one flag is high for any operand pair.
  always_comb begin
    lt = (a < b);
    eq = (a == b);
    gt = (a > b);
  end

endmodule

// File: rtl/seq_comp.sv
// Sequential magnitude comparator: walks the operands one CHUNK-bit slice per
// cycle from the MSB end and stops at the first differing slice.
// Optional feature: define SEQ_COMP_MINMAX_EN to add min_o/max_o outputs.
module seq_comp
  import seq_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             eq,
  output logic             gt
`ifdef SEQ_COMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o
`endif
);

  localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("seq_comp: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("seq_comp: WIDTH must be a multiple of CHUNK");
  end

  state_t            state, state_n;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [IW-1:0]     idx;
  logic              lt_q, eq_q, gt_q;
  logic [CHUNK-1:0]  a_s, b_s;
  logic              c_lt, c_eq, c_gt;
  logic              acc;
  logic [WIDTH-1:0]  msb_in;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_in = WIDTH'(is_signed) << (WIDTH - 1);
  assign acc    = in_valid & in_ready;
  assign a_s    = a_q[idx*CHUNK +: CHUNK];
  assign b_s    = b_q[idx*CHUNK +: CHUNK];

  seq_comp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_s),
    .b  (b_s),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = CMP;
      end
      CMP: begin
        if (!c_eq || idx == '0) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, slice walk and result flags; flags are only ever set
  // while in DONE, so they read 0 whenever out_valid is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      idx  <= '0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          a_q <= a ^ msb_in;
          b_q <= b ^ msb_in;
          idx <= IW'(N - 1);
        end
        CMP: begin
          if (!c_eq) begin
            lt_q <= c_lt;
            gt_q <= c_gt;
          end else if (idx == '0) begin
            eq_q <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: if (out_ready) begin
          lt_q <= 1'b0;
          eq_q <= 1'b0;
          gt_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign lt = lt_q;
  assign eq = eq_q;
  assign gt = gt_q;

`ifdef SEQ_COMP_MINMAX_EN
  logic             sgn_q;
  logic [WIDTH-1:0] msb_q, a_org, b_org;

  // Signedness kept so the original operands can be recovered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sgn_q <= 1'b0;
    else if (acc) sgn_q <= is_signed;
  end

  assign msb_q = WIDTH'(sgn_q) << (WIDTH - 1);
  assign a_org = a_q ^ msb_q;
  assign b_org = b_q ^ msb_q;
  // Equal operands report a for both.
  assign min_o = out_valid ? (gt_q ? b_org : a_org) : '0;
  assign max_o = out_valid ? (gt_q ? a_org : b_org) : '0;
`endif

endmodule

// File: tb/tb_seq_comp.sv
// Randomized self-checking bench for seq_comp (WIDTH=32, CHUNK=8).
module tb_seq_comp;

  localparam int W = 32;
  localparam int C = 8;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         is_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         lt, eq, gt;
`ifdef SEQ_COMP_MINMAX_EN
  logic [W-1:0] min_o, max_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_comp #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
`ifdef SEQ_COMP_MINMAX_EN
    ,
    .min_o     (min_o),
    .max_o     (max_o)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: ordering from plain integer compare; latency from the position
  // of the most significant differing chunk (sign flip affects both equally).
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                input bit s, output logic [2:0] flags, output int lat);
    longint xv, yv;
    xv = s ? longint'($signed(x)) : longint'({32'd0, x});
    yv = s ? longint'($signed(y)) : longint'({32'd0, y});
    flags = (xv < yv) ? 3'b100 : (xv == yv) ? 3'b010 : 3'b001;
    lat = N;
    for (int k = N - 1; k >= 0; k--) begin
      if (((x >> (k*C)) & 32'hFF) != ((y >> (k*C)) & 32'hFF)) begin
        lat = N - k;
        break;
      end
    end
  endfunction

  // Present a pair and let the next rising edge accept it.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit s);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = ta; b = tb; is_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; is_signed = 1'($urandom);
    chk("in_ready_busy", in_ready, 0);
  endtask

  // Wait for the result, check it, hold it, then release it.
  task automatic finish_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input bit s, input int hold);
    logic [2:0] ef;
    int el, lat;
    model(ta, tb, s, ef, el);
    lat = 0;
    while (!out_valid && lat < 3*N) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(el));
    chk("flags", {lt, eq, gt}, ef);
`ifdef SEQ_COMP_MINMAX_EN
    begin
      logic [W-1:0] emin, emax;
      emin = (ef == 3'b001) ? tb : ta;
      emax = (ef == 3'b001) ? ta : tb;
      chk("min_o", min_o, emin);
      chk("max_o", max_o, emax);
    end
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", {out_valid, in_ready}, 2'b10);
      chk("hold_flags", {lt, eq, gt}, ef);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release", {out_valid, in_ready, lt, eq, gt}, 5'b01000);
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input bit s, input int hold);
    start_op(ta, tb, s);
    finish_op(ta, tb, s, hold);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #2;
    chk("reset_state", {in_ready, out_valid, lt, eq, gt}, 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h00000005, 32'h00000003, 1'b0, 0);
    do_op(32'h80000000, 32'h7FFFFFFF, 1'b0, 0);
    do_op(32'h80000000, 32'h7FFFFFFF, 1'b1, 0);
    do_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0);
    do_op(32'h12345678, 32'h12345600, 1'b1, 5);
    do_op(32'hFFFFFFFE, 32'h00000001, 1'b1, 1);

    // Reset in the middle of a long compare.
    start_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("rst_cmp", {in_ready, out_valid, lt, eq, gt}, 5'b10000);
    #3 rst_n = 1'b1;
    do_op(32'h00000001, 32'h00000002, 1'b0, 0);

    // Reset while a result is being held.
    start_op(32'h90000000, 32'h10000000, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_done", {out_valid, gt}, 2'b11);
    rst_n = 1'b0; #1;
    chk("rst_done", {in_ready, out_valid, lt, eq, gt}, 5'b10000);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 80; i++) begin
      ra = $urandom;
      rb = $urandom;
      // Copy a random number of top chunks so every latency is exercised.
      case ($urandom_range(0, 4))
        0: rb = ra;
        1: rb = {ra[31:24], rb[23:0]};
        2: rb = {ra[31:16], rb[15:0]};
        3: rb = {ra[31:8],  rb[7:0]};
        default: ;
      endcase
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
